mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_pkg.sv | 23 ++
 rtl/arb_wait_timer.sv | 41 ++++
 rtl/mem_port_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 390 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_pkg
// Shared definitions for the CPU memory-port arbiter:
//   arb_state_t      - arbiter FSM state encoding (also exported on dbg_state)
//   FETCH_TYPE       - size code driven on MEM_type for instruction fetches
//   DEF_TIMEOUT      - default memory wait limit, in cycles
//   DEF_MAX_DSTREAK  - default number of back-to-back data grants allowed
//                      while a fetch is waiting
// ---------------------------------------------------------------------------
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_BUSY_IF = 2'd1,
      ST_BUSY_D  = 2'd2,
      ST_RESP    = 2'd3
   } arb_state_t;

   localparam logic [2:0] FETCH_TYPE      = 3'b010;
   localparam int         DEF_TIMEOUT     = 16;
   localparam int         DEF_MAX_DSTREAK = 4;

endpackage

// File: rtl/arb_wait_timer.sv
// ---------------------------------------------------------------------------
// arb_wait_timer
// Counts cycles spent waiting for the memory to answer.
//   i_clk      - clock
//   i_rst      - synchronous active-high reset
//   i_clear    - zero the count (new access granted)
//   i_enable   - one more cycle waited without an answer
//   o_expired  - this enabled cycle brings the count to TIMEOUT
// The count saturates at TIMEOUT. o_expired is combinational so the owner can
// abort in the same cycle the limit is reached, which keeps the access on the
// bus for exactly TIMEOUT cycles.
// ---------------------------------------------------------------------------
module arb_wait_timer
   import mem_port_arbiter_pkg::*;
#(
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expired
);

   localparam int              CW     = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0]   C_MAX  = CW'(TIMEOUT);
   localparam logic [CW-1:0]   C_LAST = CW'(TIMEOUT - 1);

   logic [CW-1:0] r_count;

   always_ff @(posedge i_clk) begin
      if (i_rst || i_clear) begin
         r_count <= '0;
      end else if (i_enable && (r_count != C_MAX)) begin
         r_count <= r_count + CW'(1);
      end
   end

   assign o_expired = i_enable && (r_count == C_LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares one memory port between the instruction-fetch and data requesters.
//
// Ports
//   CLK, rst                 clock, synchronous active-high reset
//   if_req/if_addr           fetch request (held until if_gnt) and address
//   if_gnt/if_valid/if_rdata fetch accept pulse, completion pulse, data
//   d_req/d_we/d_addr/d_wdata/d_type  data request fields
//   d_gnt/d_valid/d_rdata    data accept pulse, completion pulse, load data
//   MEM_req/MEM_we/MEM_addr/MEM_wdata/MEM_type  memory access (registered)
//   MEM_ready/MEM_rdata      memory completion strobe and read data
//   err                      pulse: access aborted after TIMEOUT cycles
//   cpu_stall                a request is waiting or the port is occupied
//   dbg_state                current FSM state
//
// Handshake: a requester holds *_req until the cycle *_gnt is high; the grant
// is combinational from IDLE and the request fields are latched on that edge.
// The memory sees MEM_req with stable fields until it returns MEM_ready for
// one cycle; the requester then gets exactly one *_valid pulse, with data
// zero for writes and for timed-out accesses.
// ---------------------------------------------------------------------------
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int TIMEOUT     = DEF_TIMEOUT,
   parameter int MAX_DSTREAK = DEF_MAX_DSTREAK
) (
   input  logic        CLK,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_gnt,
   output logic        if_valid,
   output logic [31:0] if_rdata,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic [2:0]  d_type,
   output logic        d_gnt,
   output logic        d_valid,
   output logic [31:0] d_rdata,
   output logic        MEM_req,
   output logic        MEM_we,
   output logic [31:0] MEM_addr,
   output logic [31:0] MEM_wdata,
   output logic [2:0]  MEM_type,
   input  logic        MEM_ready,
   input  logic [31:0] MEM_rdata,
   output logic        err,
   output logic        cpu_stall,
   output arb_state_t  dbg_state
);

   localparam int            DW    = (MAX_DSTREAK < 1) ? 1 : $clog2(MAX_DSTREAK + 1);
   localparam logic [DW-1:0] MAX_V = DW'(MAX_DSTREAK);

   arb_state_t    r_state;
   logic          r_mem_req;
   logic          r_mem_we;
   logic [31:0]   r_mem_addr;
   logic [31:0]   r_mem_wdata;
   logic [2:0]    r_mem_type;
   logic [31:0]   r_rdata;
   logic          r_if_valid;
   logic          r_d_valid;
   logic          r_err;
   logic [DW-1:0] r_dstreak;

   logic          w_idle;
   logic          w_busy;
   logic          w_fetch_wins;
   logic          w_if_gnt;
   logic          w_d_gnt;
   logic          w_expired;

   assign w_idle = (r_state == ST_IDLE) && !rst;
   assign w_busy = (r_state == ST_BUSY_IF) || (r_state == ST_BUSY_D);

   // Data normally wins; once the data side has taken MAX_DSTREAK grants in a
   // row while a fetch waited, the fetch gets the next slot.
   assign w_fetch_wins = if_req && (!d_req || (r_dstreak == MAX_V));
   assign w_if_gnt     = w_idle && w_fetch_wins;
   assign w_d_gnt      = w_idle && d_req && !w_fetch_wins;

   arb_wait_timer #(
      .TIMEOUT   (TIMEOUT)
   ) u_wait_timer (
      .i_clk     (CLK),
      .i_rst     (rst),
      .i_clear   (w_if_gnt || w_d_gnt),
      .i_enable  (w_busy && !MEM_ready),
      .o_expired (w_expired)
   );

   always_ff @(posedge CLK) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_mem_type  <= '0;
         r_rdata     <= '0;
         r_if_valid  <= 1'b0;
         r_d_valid   <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_if_valid <= 1'b0;
         r_d_valid  <= 1'b0;
         r_err      <= 1'b0;
         unique case (r_state)
            ST_IDLE: begin
               if (w_if_gnt) begin
                  r_state     <= ST_BUSY_IF;
                  r_mem_req   <= 1'b1;
                  r_mem_we    <= 1'b0;
                  r_mem_addr  <= if_addr;
                  r_mem_wdata <= '0;
                  r_mem_type  <= FETCH_TYPE;
               end else if (w_d_gnt) begin
                  r_state     <= ST_BUSY_D;
                  r_mem_req   <= 1'b1;
                  r_mem_we    <= d_we;
                  r_mem_addr  <= d_addr;
                  r_mem_wdata <= d_wdata;
                  r_mem_type  <= d_type;
               end
            end
            ST_BUSY_IF, ST_BUSY_D: begin
               // A timeout completes like a normal access but skips RESP:
               // the valid/err pulse appears while already back in IDLE.
               if (MEM_ready || w_expired) begin
                  r_state     <= MEM_ready ? ST_RESP : ST_IDLE;
                  r_rdata     <= (MEM_ready && !r_mem_we) ? MEM_rdata : '0;
                  r_err       <= !MEM_ready;
                  r_if_valid  <= (r_state == ST_BUSY_IF);
                  r_d_valid   <= (r_state == ST_BUSY_D);
                  r_mem_req   <= 1'b0;
                  r_mem_we    <= 1'b0;
                  r_mem_addr  <= '0;
                  r_mem_wdata <= '0;
                  r_mem_type  <= '0;
               end
            end
            ST_RESP: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // The streak only means something while a fetch is waiting, so any cycle
   // without if_req resets it.
   always_ff @(posedge CLK) begin
      if (rst) begin
         r_dstreak <= '0;
      end else if (w_if_gnt || !if_req) begin
         r_dstreak <= '0;
      end else if (w_d_gnt && (r_dstreak != MAX_V)) begin
         r_dstreak <= r_dstreak + DW'(1);
      end
   end

   assign if_gnt    = w_if_gnt;
   assign d_gnt     = w_d_gnt;
   assign if_valid  = r_if_valid;
   assign d_valid   = r_d_valid;
   assign if_rdata  = r_if_valid ? r_rdata : '0;
   assign d_rdata   = r_d_valid ? r_rdata : '0;
   assign err       = r_err;
   assign MEM_req   = r_mem_req;
   assign MEM_we    = r_mem_we;
   assign MEM_addr  = r_mem_addr;
   assign MEM_wdata = r_mem_wdata;
   assign MEM_type  = r_mem_type;
   assign cpu_stall = (if_req && !w_if_gnt) || (d_req && !w_d_gnt) || (r_state != ST_IDLE);
   assign dbg_state = r_state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed scenarios for fetch, contention, data streak, timeout, the
// ready-on-last-cycle boundary and reset mid-access, followed by a random run
// against a transaction-timeline model of the arbiter.
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;
   import mem_port_arbiter_pkg::*;

   localparam int T    = DEF_TIMEOUT;
   localparam int MAXD = DEF_MAX_DSTREAK;

   logic        CLK, rst;
   logic        if_req, d_req, d_we, MEM_ready;
   logic [31:0] if_addr, d_addr, d_wdata, MEM_rdata;
   logic [2:0]  d_type;
   logic        if_gnt, if_valid, d_gnt, d_valid, MEM_req, MEM_we, err, cpu_stall;
   logic [31:0] if_rdata, d_rdata, MEM_addr, MEM_wdata;
   logic [2:0]  MEM_type;
   arb_state_t  dbg_state;

   int tests_run;
   int tests_failed;

   mem_port_arbiter #(.TIMEOUT(T), .MAX_DSTREAK(MAXD)) dut (
      .CLK(CLK), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_type(d_type),
      .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata),
      .MEM_req(MEM_req), .MEM_we(MEM_we), .MEM_addr(MEM_addr), .MEM_wdata(MEM_wdata),
      .MEM_type(MEM_type), .MEM_ready(MEM_ready), .MEM_rdata(MEM_rdata),
      .err(err), .cpu_stall(cpu_stall), .dbg_state(dbg_state)
   );

   // clock / reset
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // driver tasks
   task automatic drive_idle();
      if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_type = '0;
      MEM_ready = 0; MEM_rdata = '0;
   endtask

   task automatic next_cyc();
      @(posedge CLK);
      #1;
   endtask

   task automatic smp();
      @(negedge CLK);
   endtask

   task automatic do_reset();
      rst = 1;
      drive_idle();
      next_cyc();
      next_cyc();
      rst = 0;
   endtask

   task automatic test_reset();
      logic [138:0] v;
      rst = 1;
      drive_idle();
      next_cyc();
      smp();
      v = {if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata, MEM_req, MEM_we, MEM_addr,
           MEM_wdata, MEM_type, err, cpu_stall};
      tests_run++;
      if (v !== '0) begin tests_failed++; $display("FAIL reset_outputs got=%h exp=0", v); end
      tests_run++;
      if (dbg_state !== ST_IDLE) begin tests_failed++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, ST_IDLE); end
      next_cyc();
      rst = 0;
   endtask

   task automatic test_fetch();
      logic [31:0] exp_addr;
      logic [2:0]  exp_type;
      do_reset();
      if_req = 1; if_addr = 32'h0000_0040;
      smp();
      tests_run++;
      if ({if_gnt, d_gnt} !== 2'b10) begin tests_failed++; $display("FAIL fetch_gnt got=%b exp=10", {if_gnt, d_gnt}); end
      tests_run++;
      if (cpu_stall !== 1'b0) begin tests_failed++; $display("FAIL fetch_gnt_stall got=%b exp=0", cpu_stall); end
      next_cyc();
      if_req = 0; if_addr = 32'hFFFF_FFFF;
      for (int k = 1; k <= 5; k++) begin
         MEM_ready = (k == 3);
         MEM_rdata = (k == 3) ? 32'h00A0_0093 : $urandom;
         smp();
         exp_addr = (k <= 3) ? 32'h40 : 32'h0;
         exp_type = (k <= 3) ? 3'b010 : 3'b000;
         tests_run++;
         if ({MEM_req, MEM_we, MEM_addr, MEM_type} !== {(k <= 3), 1'b0, exp_addr, exp_type}) begin
            tests_failed++;
            $display("FAIL fetch_mem k=%0d got=%b/%b/%h/%b exp=%b/0/%h/%b", k, MEM_req, MEM_we, MEM_addr, MEM_type, (k <= 3), exp_addr, exp_type);
         end
         tests_run++;
         if (if_valid !== (k == 4)) begin tests_failed++; $display("FAIL fetch_valid k=%0d got=%b exp=%b", k, if_valid, (k == 4)); end
         if (k == 4) begin
            tests_run++;
            if (if_rdata !== 32'h00A0_0093) begin tests_failed++; $display("FAIL fetch_rdata got=%h exp=00a00093", if_rdata); end
         end
         tests_run++;
         if (cpu_stall !== (k <= 4)) begin tests_failed++; $display("FAIL fetch_stall k=%0d got=%b exp=%b", k, cpu_stall, (k <= 4)); end
         next_cyc();
      end
      MEM_ready = 0;
   endtask

   task automatic test_contention();
      do_reset();
      if_req = 1; if_addr = 32'h80; d_req = 1; d_we = 0; d_addr = 32'h100; d_type = 3'b010; d_wdata = $urandom;
      smp();
      tests_run++;
      if ({if_gnt, d_gnt, cpu_stall} !== 3'b011) begin tests_failed++; $display("FAIL cont_first got=%b exp=011", {if_gnt, d_gnt, cpu_stall}); end
      next_cyc();
      d_req = 0; MEM_ready = 1; MEM_rdata = 32'h1234_5678;
      smp();
      tests_run++;
      if ({MEM_req, MEM_we, MEM_addr, MEM_type, if_gnt, cpu_stall} !== {2'b10, 32'h100, 3'b010, 2'b01}) begin
         tests_failed++;
         $display("FAIL cont_busy got=%b/%b/%h/%b/%b/%b exp=1/0/100/010/0/1", MEM_req, MEM_we, MEM_addr, MEM_type, if_gnt, cpu_stall);
      end
      next_cyc();
      MEM_ready = 0;
      smp();
      tests_run++;
      if ({d_valid, d_rdata, if_gnt, cpu_stall, MEM_req} !== {1'b1, 32'h1234_5678, 3'b010}) begin
         tests_failed++;
         $display("FAIL cont_resp got=%b/%h/%b/%b/%b exp=1/12345678/0/1/0", d_valid, d_rdata, if_gnt, cpu_stall, MEM_req);
      end
      next_cyc();
      smp();
      tests_run++;
      if ({if_gnt, d_gnt, d_valid} !== 3'b100) begin tests_failed++; $display("FAIL cont_fetch_gnt got=%b exp=100", {if_gnt, d_gnt, d_valid}); end
      next_cyc();
      if_req = 0; MEM_ready = 1; MEM_rdata = 32'hCAFE_0001;
      smp();
      tests_run++;
      if ({MEM_addr, MEM_type} !== {32'h80, 3'b010}) begin tests_failed++; $display("FAIL cont_fetch_mem got=%h/%b exp=80/010", MEM_addr, MEM_type); end
      next_cyc();
      MEM_ready = 0;
      smp();
      tests_run++;
      if ({if_valid, if_rdata} !== {1'b1, 32'hCAFE_0001}) begin tests_failed++; $display("FAIL cont_fetch_valid got=%b/%h exp=1/cafe0001", if_valid, if_rdata); end
      next_cyc();
   endtask

   task automatic test_dstreak();
      int  n;
      bit  exp_fetch;
      do_reset();
      if_req = 1; if_addr = 32'h400; d_req = 1; d_we = 1; d_addr = 32'h300; d_wdata = 32'h5555_AAAA; d_type = 3'b001;
      MEM_ready = 1;
      n = 0;
      for (int cyc = 0; cyc < 60 && n < 10; cyc++) begin
         smp();
         if (if_gnt === 1'b1 || d_gnt === 1'b1) begin
            exp_fetch = ((n % (MAXD + 1)) == MAXD);
            tests_run++;
            if ({if_gnt, d_gnt} !== {exp_fetch, !exp_fetch}) begin
               tests_failed++;
               $display("FAIL streak_order grant=%0d got=%b exp=%b", n, {if_gnt, d_gnt}, {exp_fetch, !exp_fetch});
            end
            n++;
         end
         next_cyc();
      end
      tests_run++;
      if (n != 10) begin tests_failed++; $display("FAIL streak_count got=%0d exp=10", n); end
      drive_idle();
   endtask

   task automatic test_timeout();
      do_reset();
      d_req = 1; d_we = 1; d_addr = 32'h200; d_wdata = 32'hDEAD_BEEF; d_type = 3'b010;
      smp();
      tests_run++;
      if (d_gnt !== 1'b1) begin tests_failed++; $display("FAIL to_gnt got=%b exp=1", d_gnt); end
      next_cyc();
      d_req = 0; d_addr = '0; d_wdata = '0; d_we = 0;
      for (int k = 1; k <= T + 2; k++) begin
         MEM_ready = 0;
         smp();
         if (k <= T) begin
            tests_run++;
            if ({MEM_req, MEM_we, MEM_addr, MEM_wdata, MEM_type, err, d_valid} !== {2'b11, 32'h200, 32'hDEAD_BEEF, 3'b010, 2'b00}) begin
               tests_failed++;
               $display("FAIL to_busy k=%0d got=%b/%b/%h/%h/%b/%b/%b", k, MEM_req, MEM_we, MEM_addr, MEM_wdata, MEM_type, err, d_valid);
            end
         end else if (k == T + 1) begin
            tests_run++;
            if ({MEM_req, err, d_valid, d_rdata} !== {3'b011, 32'h0} || dbg_state !== ST_IDLE) begin
               tests_failed++;
               $display("FAIL to_abort got=%b/%b/%b/%h/%0d exp=0/1/1/0/0", MEM_req, err, d_valid, d_rdata, dbg_state);
            end
         end else begin
            tests_run++;
            if ({err, d_valid} !== 2'b00) begin tests_failed++; $display("FAIL to_after got=%b exp=00", {err, d_valid}); end
         end
         next_cyc();
      end
      // ready arriving on the last allowed wait cycle is a success
      d_req = 1; d_we = 0; d_addr = 32'h204; d_type = 3'b010;
      smp();
      tests_run++;
      if (d_gnt !== 1'b1) begin tests_failed++; $display("FAIL edge_gnt got=%b exp=1", d_gnt); end
      next_cyc();
      d_req = 0;
      for (int k = 1; k <= T + 1; k++) begin
         MEM_ready = (k == T);
         MEM_rdata = (k == T) ? 32'h0BAD_F00D : $urandom;
         smp();
         if (k == T) begin
            tests_run++;
            if ({MEM_req, err} !== 2'b10) begin tests_failed++; $display("FAIL edge_last got=%b exp=10", {MEM_req, err}); end
         end
         if (k == T + 1) begin
            tests_run++;
            if ({err, d_valid, d_rdata} !== {2'b01, 32'h0BAD_F00D}) begin
               tests_failed++;
               $display("FAIL edge_resp got=%b/%b/%h exp=0/1/0badf00d", err, d_valid, d_rdata);
            end
         end
         next_cyc();
      end
      MEM_ready = 0;
   endtask

   task automatic test_reset_mid();
      do_reset();
      d_req = 1; d_we = 0; d_addr = 32'h300; d_type = 3'b000;
      smp();
      tests_run++;
      if (d_gnt !== 1'b1) begin tests_failed++; $display("FAIL rmid_gnt got=%b exp=1", d_gnt); end
      next_cyc();
      d_req = 0;
      next_cyc();
      next_cyc();
      rst = 1;
      next_cyc();
      rst = 0; MEM_ready = 1; MEM_rdata = 32'h7777_7777;
      for (int k = 0; k < 4; k++) begin
         smp();
         tests_run++;
         if ({MEM_req, d_valid, err} !== 3'b000 || dbg_state !== ST_IDLE) begin
            tests_failed++;
            $display("FAIL rmid_quiet k=%0d got=%b/%0d exp=000/0", k, {MEM_req, d_valid, err}, dbg_state);
         end
         next_cyc();
      end
      MEM_ready = 0; if_req = 1; if_addr = 32'h500;
      smp();
      tests_run++;
      if ({if_gnt, d_gnt} !== 2'b10) begin tests_failed++; $display("FAIL rmid_fetch_gnt got=%b exp=10", {if_gnt, d_gnt}); end
      next_cyc();
      if_req = 0; MEM_ready = 1; MEM_rdata = 32'h0000_1111;
      smp();
      tests_run++;
      if ({MEM_req, MEM_addr} !== {1'b1, 32'h500}) begin tests_failed++; $display("FAIL rmid_fetch_mem got=%b/%h exp=1/500", MEM_req, MEM_addr); end
      next_cyc();
      MEM_ready = 0;
      smp();
      tests_run++;
      if ({if_valid, if_rdata} !== {1'b1, 32'h0000_1111}) begin tests_failed++; $display("FAIL rmid_fetch_valid got=%b/%h exp=1/00001111", if_valid, if_rdata); end
      next_cyc();
   endtask

   // Timeline model: a grant at cycle g with memory wait L puts the access on
   // the bus for cycles g+1..g+1+L and responds at g+2+L; the port is free
   // again at g+3+L. With no answer the bus holds for T cycles and the
   // err/valid response lands at g+T+1, when a new grant is already allowed.
   task automatic test_random(input int n_cycles);
      bit          if_pend, d_pend, busy, occ, e_ig, e_dg, e_ifv, e_dv, e_err, e_stall;
      bit          cur_if, cur_we, cur_err;
      logic [31:0] cur_addr, cur_wdata, cur_rdval, exp_rd;
      logic [2:0]  cur_type;
      int          streak, g_cyc, busy_lo, busy_hi, rdy_cyc, resp_cyc, free_at, lat;
      if_pend = 0; d_pend = 0; streak = 0; g_cyc = -10; busy_lo = 1; busy_hi = 0;
      rdy_cyc = -1; resp_cyc = -1; free_at = 0; lat = 0;
      cur_if = 0; cur_we = 0; cur_err = 0; cur_addr = '0; cur_wdata = '0; cur_rdval = '0;
      cur_type = '0; exp_rd = '0;
      do_reset();
      for (int c = 0; c < n_cycles; c++) begin
         if (!if_pend && $urandom_range(0, 2) == 0) begin if_pend = 1; if_addr = $urandom; end
         if (!d_pend && $urandom_range(0, 2) == 0) begin
            d_pend = 1; d_we = 1'($urandom_range(0, 1)); d_addr = $urandom; d_wdata = $urandom;
            d_type = 3'($urandom_range(0, 7));
         end
         if_req = if_pend; d_req = d_pend;
         busy = (c >= busy_lo) && (c <= busy_hi);
         occ  = (c > g_cyc) && (c < free_at);
         MEM_ready = (c == rdy_cyc) || (!busy && $urandom_range(0, 3) == 0);
         MEM_rdata = (c == rdy_cyc) ? cur_rdval : $urandom;
         e_ifv = (c == resp_cyc) && cur_if;
         e_dv  = (c == resp_cyc) && !cur_if;
         e_err = (c == resp_cyc) && cur_err;
         e_ig  = (c >= free_at) && if_pend && (!d_pend || streak == MAXD);
         e_dg  = (c >= free_at) && d_pend && !e_ig;
         e_stall = (if_pend && !e_ig) || (d_pend && !e_dg) || occ;
         smp();
         tests_run++;
         if ({if_gnt, d_gnt} !== {e_ig, e_dg}) begin
            tests_failed++; $display("FAIL rnd_gnt cyc=%0d got=%b exp=%b", c, {if_gnt, d_gnt}, {e_ig, e_dg});
         end
         tests_run++;
         if (MEM_req !== busy || MEM_we !== (busy && cur_we) || MEM_addr !== (busy ? cur_addr : 32'h0) ||
             MEM_type !== (busy ? cur_type : 3'b000)) begin
            tests_failed++;
            $display("FAIL rnd_mem cyc=%0d got=%b/%b/%h/%b exp=%b/%b/%h/%b", c, MEM_req, MEM_we, MEM_addr, MEM_type,
                     busy, busy && cur_we, busy ? cur_addr : 32'h0, busy ? cur_type : 3'b000);
         end
         if (busy && cur_we) begin
            tests_run++;
            if (MEM_wdata !== cur_wdata) begin tests_failed++; $display("FAIL rnd_wdata cyc=%0d got=%h exp=%h", c, MEM_wdata, cur_wdata); end
         end
         tests_run++;
         if ({if_valid, d_valid, err} !== {e_ifv, e_dv, e_err}) begin
            tests_failed++; $display("FAIL rnd_resp cyc=%0d got=%b exp=%b", c, {if_valid, d_valid, err}, {e_ifv, e_dv, e_err});
         end
         if (e_ifv) begin
            tests_run++;
            if (if_rdata !== exp_rd) begin tests_failed++; $display("FAIL rnd_if_rdata cyc=%0d got=%h exp=%h", c, if_rdata, exp_rd); end
         end
         if (e_dv) begin
            tests_run++;
            if (d_rdata !== exp_rd) begin tests_failed++; $display("FAIL rnd_d_rdata cyc=%0d got=%h exp=%h", c, d_rdata, exp_rd); end
         end
         tests_run++;
         if (cpu_stall !== e_stall) begin tests_failed++; $display("FAIL rnd_stall cyc=%0d got=%b exp=%b", c, cpu_stall, e_stall); end
         if (e_ig || e_dg) begin
            cur_if    = e_ig;
            cur_we    = e_dg && d_we;
            cur_addr  = e_ig ? if_addr : d_addr;
            cur_wdata = d_wdata;
            cur_type  = e_ig ? 3'b010 : d_type;
            cur_rdval = $urandom;
            case ($urandom_range(0, 9))
               0, 1, 2, 3, 4, 5: lat = $urandom_range(0, 3);
               6, 7:             lat = T - 1;
               default:          lat = T;
            endcase
            g_cyc = c; busy_lo = c + 1;
            if (lat < T) begin
               rdy_cyc = c + 1 + lat; busy_hi = rdy_cyc; resp_cyc = c + 2 + lat; free_at = c + 3 + lat;
               cur_err = 0; exp_rd = cur_we ? 32'h0 : cur_rdval;
            end else begin
               rdy_cyc = -1; busy_hi = c + T; resp_cyc = c + T + 1; free_at = c + T + 1;
               cur_err = 1; exp_rd = 32'h0;
            end
         end
         if (e_ig || !if_pend) streak = 0;
         else if (e_dg && streak < MAXD) streak = streak + 1;
         if (e_ig) if_pend = 0;
         if (e_dg) d_pend = 0;
         next_cyc();
      end
      drive_idle();
   endtask

   // sequence and final report
   initial begin
      tests_run = 0;
      tests_failed = 0;
      drive_idle();
      rst = 1;
      test_reset();
      test_fetch();
      test_contention();
      test_dstreak();
      test_timeout();
      test_reset_mid();
      test_random(1500);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
